// File: rtl/sqrt_square_check_if.sv
// Request/result bundle between a sqrt producer and the square-check block.
// Carries the root/remainder pair in and the reconstructed value and flags out.
// No flow control beyond init/busy/done.
interface sqrt_square_check_if #(parameter int W = 8);
   logic           init;
   logic [W-1:0]   in_root;
   logic [W:0]     in_rem;
   logic           busy;
   logic           done;
   logic [2*W-1:0] out_sq;
   logic [2*W-1:0] out_a;
   logic           rem_err;
   logic           ovf;

   modport master (
      output init, in_root, in_rem,
      input  busy, done, out_sq, out_a, rem_err, ovf
   );

   modport slave (
      input  init, in_root, in_rem,
      output busy, done, out_sq, out_a, rem_err, ovf
   );
endinterface

// File: rtl/sqrt_square_check.sv
// Rebuilds A = R*R + Q from a sqrt root/remainder pair with a shift-and-add squarer.
// Latency: done pulses W+2 falling edges after init is taken; back in IDLE after W+3.
// Backpressure: init is only sampled in IDLE; requests while busy are dropped.
module sqrt_square_check #(
   parameter int W = 8
) (
   input logic               clk,
   input logic               reset,
   sqrt_square_check_if.slave bus
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, MUL, ADDREM, FIN} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   mplr_q, mplr_d;
   logic [W-1:0]   root_q, root_d;
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W:0]     rem_q, rem_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] out_sq_q, out_sq_d;
   logic [2*W-1:0] out_a_q, out_a_d;
   logic           rem_err_q, rem_err_d;
   logic           ovf_q, ovf_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [2*W:0]   sum;

   // One extra bit so the carry out of the remainder add becomes ovf.
   assign sum = {1'b0, acc_q} + {{W{1'b0}}, rem_q};

   // Next-state and datapath: W fixed squarer iterations, then add remainder, then report.
   always_comb begin
      state_d   = state_q;
      mplr_d    = mplr_q;
      root_d    = root_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      out_sq_d  = out_sq_q;
      out_a_d   = out_a_q;
      rem_err_d = rem_err_q;
      ovf_d     = ovf_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // busy stays up for the edge after FIN, then drops unless a new request lands.
            busy_d = bus.init;
            if (bus.init) begin
               mplr_d  = bus.in_root;
               root_d  = bus.in_root;
               mcand_d = {{W{1'b0}}, bus.in_root};
               rem_d   = bus.in_rem;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            // No early exit on a zero multiplier: latency must not depend on data.
            if (mplr_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = ADDREM;
            end
         end
         ADDREM: begin
            out_sq_d  = acc_q;
            out_a_d   = sum[2*W-1:0];
            ovf_d     = sum[2*W];
            rem_err_d = rem_q > {root_q, 1'b0};
            state_d   = FIN;
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, updated on the falling edge to line up with the sqrt unit.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         mplr_q    <= '0;
         root_q    <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         out_sq_q  <= '0;
         out_a_q   <= '0;
         rem_err_q <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mplr_q    <= mplr_d;
         root_q    <= root_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         out_sq_q  <= out_sq_d;
         out_a_q   <= out_a_d;
         rem_err_q <= rem_err_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.out_sq  = out_sq_q;
   assign bus.out_a   = out_a_q;
   assign bus.rem_err = rem_err_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_sqrt_square_check.sv
// Directed and round-trip checks for sqrt_square_check (W=8).
// Inputs are driven and outputs sampled on the rising edge; the DUT acts on the falling edge.
module tb_sqrt_square_check;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;

   sqrt_square_check_if #(.W(8)) bus ();

   sqrt_square_check #(.W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int isqrt(input int a);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= a) r++;
      return r;
   endfunction

   // One full transaction with latency, result and pulse-width checks.
   task automatic run(input logic [7:0] r, input logic [8:0] q,
                      input logic [15:0] esq, input logic [15:0] ea,
                      input logic eerr, input logic eovf, input string tag);
      int n;
      bit seen;
      @(posedge clk);
      bus.init = 1'b1; bus.in_root = r; bus.in_rem = q;
      @(negedge clk);
      @(posedge clk);
      bus.init = 1'b0;
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         @(posedge clk);
         if (bus.done) seen = 1'b1;
      end
      check({tag, " latency"}, 32'(n), 32'd10);
      check({tag, " out_sq"}, 32'(bus.out_sq), 32'(esq));
      check({tag, " out_a"}, 32'(bus.out_a), 32'(ea));
      check({tag, " rem_err"}, 32'(bus.rem_err), 32'(eerr));
      check({tag, " ovf"}, 32'(bus.ovf), 32'(eovf));
      @(negedge clk);
      @(posedge clk);
      check({tag, " done width"}, 32'(bus.done), 32'd0);
      check({tag, " busy drop"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int n;
      bit seen;
      int a, r, q;
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.init = 1'b0; bus.in_root = '0; bus.in_rem = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst out_sq", 32'(bus.out_sq), 32'd0);
      check("rst out_a", 32'(bus.out_a), 32'd0);
      check("rst rem_err", 32'(bus.rem_err), 32'd0);
      check("rst ovf", 32'(bus.ovf), 32'd0);
      @(posedge clk);
      reset = 1'b0;

      // Small directed values, including an illegal remainder without carry.
      run(8'd0, 9'd0, 16'd0, 16'd0, 1'b0, 1'b0, "r0q0");
      run(8'd1, 9'd2, 16'd1, 16'd3, 1'b0, 1'b0, "r1q2");
      run(8'd3, 9'd7, 16'd9, 16'd16, 1'b1, 1'b0, "r3q7");

      // Reset in the middle of MUL clears everything and suppresses done.
      @(posedge clk);
      bus.init = 1'b1; bus.in_root = 8'd200; bus.in_rem = 9'd0;
      @(negedge clk);
      @(posedge clk);
      bus.init = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      reset = 1'b1;
      #1;
      check("midrst busy", 32'(bus.busy), 32'd0);
      check("midrst done", 32'(bus.done), 32'd0);
      check("midrst out_sq", 32'(bus.out_sq), 32'd0);
      check("midrst out_a", 32'(bus.out_a), 32'd0);
      check("midrst rem_err", 32'(bus.rem_err), 32'd0);
      check("midrst ovf", 32'(bus.ovf), 32'd0);
      @(posedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (14) begin
         @(posedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("midrst no done", 32'(seen), 32'd0);

      run(8'd12, 9'd5, 16'd144, 16'd149, 1'b0, 1'b0, "r12q5");
      run(8'd255, 9'd510, 16'd65025, 16'd65535, 1'b0, 1'b0, "max");
      run(8'd255, 9'd511, 16'd65025, 16'd0, 1'b1, 1'b1, "ovf");

      // init held high: back-to-back runs, one done per run, busy-time input change ignored.
      @(posedge clk);
      bus.init = 1'b1; bus.in_root = 8'd10; bus.in_rem = 9'd3;
      @(negedge clk);
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         if (bus.done) seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      check("held latency1", 32'(n), 32'd10);
      check("held out_a1", 32'(bus.out_a), 32'd103);
      check("held out_sq1", 32'(bus.out_sq), 32'd100);
      @(negedge clk);
      @(posedge clk);
      check("held single pulse", 32'(bus.done), 32'd0);
      check("held restart busy", 32'(bus.busy), 32'd1);
      bus.in_root = 8'd50; bus.in_rem = 9'd0;
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         @(posedge clk);
         if (bus.done) seen = 1'b1;
      end
      bus.init = 1'b0;
      check("held latency2", 32'(n), 32'd10);
      check("held out_a2", 32'(bus.out_a), 32'd103);
      check("held out_sq2", 32'(bus.out_sq), 32'd100);
      @(negedge clk);
      @(posedge clk);
      check("held end busy", 32'(bus.busy), 32'd0);

      // Round trip through a reference integer square root.
      for (int i = 0; i < 1000; i++) begin
         a = int'($urandom_range(65535));
         r = isqrt(a);
         q = a - r * r;
         run(8'(r), 9'(q), 16'(r * r), 16'(a), 1'b0, 1'b0, "roundtrip");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
